// File: rtl/pipe_mul_add_if.sv
// Operand/result bundle for pipe_mul_add: one operand set in, one reconstructed dividend out.
interface pipe_mul_add_if #(
  parameter int QUOT_W = 32,
  parameter int SOR_W  = 32
);
  logic                      valid_i;
  logic [QUOT_W-1:0]         quotient_i;
  logic [SOR_W-1:0]          divisor_i;
  logic [SOR_W-1:0]          remainder_i;
  logic                      valid_o;
  logic [QUOT_W+SOR_W-1:0]   dividend_o;
  logic                      rem_err_o;
  logic                      busy_o;

  modport master (
    output valid_i, quotient_i, divisor_i, remainder_i,
    input  valid_o, dividend_o, rem_err_o, busy_o
  );

  modport slave (
    input  valid_i, quotient_i, divisor_i, remainder_i,
    output valid_o, dividend_o, rem_err_o, busy_o
  );
endinterface

// File: rtl/pipe_mul_add.sv
// Pipelined quotient*divisor+remainder, one shift-add per quotient bit, QUOT_W cycles latency.
// Also flags operand pairs whose remainder is not smaller than the divisor.
module pipe_mul_add #(
  parameter int QUOT_W = 32,
  parameter int SOR_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_mul_add_if.slave bus
);
  localparam int ACC_W = QUOT_W + SOR_W;

  // Stage j holds the sum with quotient bits 0..j already folded in, so the
  // bit-0 add happens on the input register and the last stage is the result.
  logic [ACC_W-1:0]  acc_r [QUOT_W];
  logic [QUOT_W-1:0] q_r   [QUOT_W-1];
  logic [SOR_W-1:0]  d_r   [QUOT_W-1];
  logic [QUOT_W-1:0] v_r;
  logic [QUOT_W-1:0] err_r;

  function automatic logic [ACC_W-1:0] partial(
    input logic [QUOT_W-1:0] q,
    input logic [SOR_W-1:0]  d,
    input int                k
  );
    logic [ACC_W-1:0] d_ext;
    d_ext = {{QUOT_W{1'b0}}, d};
    return q[k] ? (d_ext << k) : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < QUOT_W; k++) acc_r[k] <= '0;
      for (int k = 0; k < QUOT_W - 1; k++) begin
        q_r[k] <= '0;
        d_r[k] <= '0;
      end
      v_r   <= '0;
      err_r <= '0;
    end else begin
      v_r[0]   <= bus.valid_i;
      err_r[0] <= (bus.remainder_i >= bus.divisor_i);
      acc_r[0] <= {{QUOT_W{1'b0}}, bus.remainder_i}
                  + partial(bus.quotient_i, bus.divisor_i, 0);
      if (QUOT_W > 1) begin
        q_r[0] <= bus.quotient_i;
        d_r[0] <= bus.divisor_i;
      end
      for (int k = 1; k < QUOT_W; k++) begin
        v_r[k]   <= v_r[k-1];
        err_r[k] <= err_r[k-1];
        acc_r[k] <= acc_r[k-1] + partial(q_r[k-1], d_r[k-1], k);
        if (k < QUOT_W - 1) begin
          q_r[k] <= q_r[k-1];
          d_r[k] <= d_r[k-1];
        end
      end
    end
  end

  assign bus.valid_o    = v_r[QUOT_W-1];
  assign bus.dividend_o = acc_r[QUOT_W-1];
  assign bus.rem_err_o  = err_r[QUOT_W-1];
  assign bus.busy_o     = |v_r;

endmodule

// File: tb/tb_pipe_mul_add.sv
// Scoreboard bench for pipe_mul_add: an 8/8 instance for directed cases and a 32/32 instance for divider round trips.
module tb_pipe_mul_add;
  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_mul_add_if #(.QUOT_W(8),  .SOR_W(8))  bus8 ();
  pipe_mul_add_if #(.QUOT_W(32), .SOR_W(32)) bus32 ();

  pipe_mul_add #(.QUOT_W(8), .SOR_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  pipe_mul_add #(.QUOT_W(32), .SOR_W(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid8 = 0;
  int n_busy8  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus8.busy_o) n_busy8++;
    if (bus8.valid_o) begin
      n_valid8++;
      if (q8.size() == 0) begin
        check("unexpected_valid8", {63'd0, bus8.valid_o}, 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("dividend8", {48'd0, bus8.dividend_o}, e8.val);
        check("rem_err8", {63'd0, bus8.rem_err_o}, {63'd0, e8.err});
        check("latency8", 64'(cyc - e8.cyc), 64'd8);
      end
    end
  end

  always @(negedge clk) begin
    if (bus32.valid_o) begin
      if (q32.size() == 0) begin
        check("unexpected_valid32", {63'd0, bus32.valid_o}, 64'd0);
      end else begin
        e32 = q32.pop_front();
        check("roundtrip32", bus32.dividend_o, e32.val);
        check("rem_err32", {63'd0, bus32.rem_err_o}, {63'd0, e32.err});
        check("latency32", 64'(cyc - e32.cyc), 64'd32);
      end
    end
  end

  // Called just after a rising edge; holds the operands for one cycle.
  task automatic issue8(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r);
    exp_t e;
    bus8.valid_i     = 1'b1;
    bus8.quotient_i  = q;
    bus8.divisor_i   = d;
    bus8.remainder_i = r;
    e.val = 64'(q) * 64'(d) + 64'(r);
    e.err = (r >= d);
    e.cyc = cyc;
    q8.push_back(e);
    @(posedge clk);
    #1;
    bus8.valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dvd, dsr;
    bus8.valid_i = 1'b0;  bus8.quotient_i = '0;  bus8.divisor_i = '0;  bus8.remainder_i = '0;
    bus32.valid_i = 1'b0; bus32.quotient_i = '0; bus32.divisor_i = '0; bus32.remainder_i = '0;

    #1 rst = 1'b1;
    #2;
    check("rst_valid8",    {63'd0, bus8.valid_o},   64'd0);
    check("rst_dividend8", {48'd0, bus8.dividend_o}, 64'd0);
    check("rst_err8",      {63'd0, bus8.rem_err_o}, 64'd0);
    check("rst_busy8",     {63'd0, bus8.busy_o},    64'd0);
    check("rst_valid32",   {63'd0, bus32.valid_o},  64'd0);
    check("rst_busy32",    {63'd0, bus32.busy_o},   64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_dividend8", {48'd0, bus8.dividend_o}, 64'd0);
    check("post_rst_err8",      {63'd0, bus8.rem_err_o}, 64'd0);

    // single op: one result, busy for exactly the pipeline depth
    n_busy8 = 0;
    n_valid8 = 0;
    issue8(8'd13, 8'd7, 8'd5);
    repeat (12) @(posedge clk);
    #1;
    check("single_busy_cycles",  64'(n_busy8),  64'd8);
    check("single_valid_cycles", 64'(n_valid8), 64'd1);

    // extremes and edge operands
    issue8(8'd255, 8'd255, 8'd254);
    issue8(8'd255, 8'd255, 8'd255);
    issue8(8'd200, 8'd0,   8'd9);
    issue8(8'd0,   8'd50,  8'd3);
    repeat (12) @(posedge clk);
    #1;

    // back-to-back random stream
    n_valid8 = 0;
    for (int i = 0; i < 20; i++)
      issue8(8'($urandom), 8'($urandom), 8'($urandom));
    repeat (12) @(posedge clk);
    #1;
    check("stream_valid_cycles", 64'(n_valid8), 64'd20);

    // reset with four ops in flight
    for (int i = 0; i < 4; i++)
      issue8(8'(i + 3), 8'd11, 8'd2);
    #3;
    check("busy_before_rst", {63'd0, bus8.busy_o}, 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid8",    {63'd0, bus8.valid_o},   64'd0);
    check("midrst_busy8",     {63'd0, bus8.busy_o},    64'd0);
    check("midrst_dividend8", {48'd0, bus8.dividend_o}, 64'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    n_valid8 = 0;
    issue8(8'd21, 8'd9, 8'd4);
    repeat (15) @(posedge clk);
    #1;
    check("after_rst_valid_cycles", 64'(n_valid8), 64'd1);
    check("drain8", 64'(q8.size()), 64'd0);

    // divider round trip on the 32/32 instance
    for (int i = 0; i < 10000; i++) begin
      exp_t e;
      dvd = $urandom;
      dsr = $urandom >> $urandom_range(0, 31);
      if (dsr == 32'd0) dsr = 32'd1;
      bus32.valid_i     = 1'b1;
      bus32.quotient_i  = dvd / dsr;
      bus32.divisor_i   = dsr;
      bus32.remainder_i = dvd % dsr;
      e.val = {32'd0, dvd};
      e.err = 1'b0;
      e.cyc = cyc;
      q32.push_back(e);
      @(posedge clk);
      #1;
    end
    bus32.valid_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("drain32", 64'(q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
